// File: rtl/wechem_pkg.sv
// Shared types for the electrochemistry run sequencer: FSM states, error codes, default widths.
// Pure declarations; no latency or flow-control behaviour of its own.
package wechem_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int SWP_W_DEF = 16;

  typedef enum logic [3:0] {
    IDLE,
    CFG,
    CFG_WAIT,
    TASK,
    TASK_WAIT,
    FLIP,
    DRAIN,
    GAP,
    FINISH,
    ERR
  } seq_state_e;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_SPI_TO      = 2'd1;
  localparam logic [1:0] ERR_TASK_TO     = 2'd2;
  localparam logic [1:0] ERR_DRAIN_ABORT = 2'd3;

  // States in which the timeout timer is allowed to expire.
  function automatic logic is_wait(seq_state_e s);
    return (s == CFG_WAIT) || (s == TASK_WAIT) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating cycle counter with synchronous clear; last_o flags the final cycle of a limit-cycle window.
// last_o is combinational from the count register only; a limit of 0 never asserts last_o.
module seq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (limit_i != '0) && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/exp_sequencer.sv
// Run scheduler: per sweep triggers SPI config, then the task, then flips and drains the ping-pong FIFO.
// All outputs registered from current state: start or done event to next trigger is 2 cycles; waits bounded by t_timeout.
module exp_sequencer import wechem_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SWP_W = SWP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SWP_W-1:0] n_sweep,
  input  logic [CNT_W-1:0] t_gap,
  input  logic [CNT_W-1:0] t_timeout,
  input  logic             done_spi,
  input  logic             done_task,
  input  logic             full_ppfifo,
  output logic             trigger_config,
  output logic             trigger_task,
  output logic             force_flip,
  output logic             busy,
  output logic             run_done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [SWP_W-1:0] sweep_idx
);

  seq_state_e       state_q, state_d;
  logic [SWP_W-1:0] n_sweep_q, n_sweep_d;
  logic [SWP_W-1:0] sweep_idx_q, sweep_idx_d, sweep_inc;
  logic [CNT_W-1:0] t_gap_q, t_gap_d;
  logic [CNT_W-1:0] t_timeout_q, t_timeout_d;
  logic [1:0]       pend_code_q, pend_code_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_q, err_d;
  logic             run_done_q, run_done_d;
  logic             trig_cfg_q, trig_task_q, flip_q, busy_q;
  logic             done_spi_q, done_task_q;
  logic             spi_ev, task_ev, drained;
  logic             tmr_clr, to_last, gap_last;

  assign spi_ev    = done_spi & ~done_spi_q;
  assign task_ev   = done_task & ~done_task_q;
  assign sweep_inc = sweep_idx_q + 1'b1;
  // flip_q is high during the first DRAIN cycle, which enforces the one-cycle minimum.
  assign drained   = !full_ppfifo && !flip_q;
  assign tmr_clr   = (state_d != state_q);

  seq_timer #(.W(CNT_W)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (is_wait(state_q)),
    .limit_i (t_timeout_q),
    .last_o  (to_last)
  );

  seq_timer #(.W(CNT_W)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (state_q == GAP),
    .limit_i (t_gap_q),
    .last_o  (gap_last)
  );

  always_comb begin
    state_d     = state_q;
    n_sweep_d   = n_sweep_q;
    t_gap_d     = t_gap_q;
    t_timeout_d = t_timeout_q;
    sweep_idx_d = sweep_idx_q;
    pend_code_d = pend_code_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    run_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d       = 1'b0;
          err_code_d  = ERR_NONE;
          pend_code_d = ERR_NONE;
          sweep_idx_d = '0;
          if (n_sweep == '0) begin
            run_done_d = 1'b1;
          end else begin
            n_sweep_d   = n_sweep;
            t_gap_d     = t_gap;
            t_timeout_d = t_timeout;
            state_d     = CFG;
          end
        end
      end
      CFG: state_d = CFG_WAIT;
      CFG_WAIT: begin
        if (spi_ev) begin
          state_d = TASK;
        end else if (to_last) begin
          state_d     = ERR;
          pend_code_d = ERR_SPI_TO;
        end
      end
      TASK: state_d = TASK_WAIT;
      TASK_WAIT: begin
        if (task_ev) begin
          state_d = FLIP;
        end else if (to_last) begin
          state_d     = ERR;
          pend_code_d = ERR_TASK_TO;
        end
      end
      FLIP: state_d = DRAIN;
      DRAIN: begin
        if (drained) begin
          sweep_idx_d = sweep_inc;
          if (sweep_inc == n_sweep_q) begin
            state_d = FINISH;
          end else if (t_gap_q == '0) begin
            state_d = CFG;
          end else begin
            state_d = GAP;
          end
        end else if (to_last) begin
          state_d     = ERR;
          pend_code_d = ERR_DRAIN_ABORT;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = CFG;
        end
      end
      FINISH: begin
        run_done_d = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        run_done_d = 1'b1;
        err_d      = 1'b1;
        err_code_d = pend_code_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ERR itself is excluded so a held abort cannot trap the FSM there.
    if (abort && (state_q != IDLE) && (state_q != ERR)) begin
      state_d     = ERR;
      pend_code_d = ERR_DRAIN_ABORT;
      sweep_idx_d = sweep_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      n_sweep_q   <= '0;
      t_gap_q     <= '0;
      t_timeout_q <= '0;
      sweep_idx_q <= '0;
      pend_code_q <= ERR_NONE;
      err_code_q  <= ERR_NONE;
      err_q       <= 1'b0;
      run_done_q  <= 1'b0;
      trig_cfg_q  <= 1'b0;
      trig_task_q <= 1'b0;
      flip_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_spi_q  <= 1'b0;
      done_task_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_sweep_q   <= n_sweep_d;
      t_gap_q     <= t_gap_d;
      t_timeout_q <= t_timeout_d;
      sweep_idx_q <= sweep_idx_d;
      pend_code_q <= pend_code_d;
      err_code_q  <= err_code_d;
      err_q       <= err_d;
      run_done_q  <= run_done_d;
      trig_cfg_q  <= (state_q == CFG);
      trig_task_q <= (state_q == TASK);
      flip_q      <= (state_q == FLIP);
      busy_q      <= (state_d != IDLE);
      done_spi_q  <= done_spi;
      done_task_q <= done_task;
    end
  end

  assign trigger_config = trig_cfg_q;
  assign trigger_task   = trig_task_q;
  assign force_flip     = flip_q;
  assign busy           = busy_q;
  assign run_done       = run_done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;
  assign sweep_idx      = sweep_idx_q;

endmodule
